// File: rtl/pt2262_encoder.sv
// PT2262-style remote-control encoder.
// Serialises a 12-trit code plus a sync bit onto DOUT, timed by ticks derived
// from the divided oscillator clock. Words repeat while TE is high, with a
// minimum burst of WORDS_MIN words per transmit request.
module pt2262_encoder #(
  parameter int unsigned TRITS      = 12,
  parameter int unsigned WORDS_MIN  = 4,
  parameter int unsigned TRIT_TICKS = 32,
  parameter int unsigned SYNC_TICKS = 128
) (
  input  logic               INPUT_CLK,
  input  logic               RST,
  input  logic               OSC_CLK,
  input  logic               TE,
  input  logic [2*TRITS-1:0] CODE,
  output logic               DOUT,
  output logic               BUSY,
  output logic               WORD_DONE
);

  localparam int unsigned PhaseW = $clog2(SYNC_TICKS);
  localparam int unsigned IdxW   = $clog2(TRITS);
  localparam int unsigned CntW   = $clog2(WORDS_MIN + 1);

  localparam logic [PhaseW-1:0] TritLast = PhaseW'(TRIT_TICKS - 1);
  localparam logic [PhaseW-1:0] SyncLast = PhaseW'(SYNC_TICKS - 1);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(TRITS - 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(WORDS_MIN);
  localparam logic [PhaseW-1:0] SyncHigh = PhaseW'(4);

  typedef enum logic [1:0] {StIdle, StTrit, StSync} state_e;

  // Waveform of one 32-tick trit: two 16-tick halves, each a short (4) or
  // long (12) high pulse. '0' = short/short, '1' = long/long, 'F' = short/long.
  function automatic logic trit_level(input logic [1:0] trit, input logic [4:0] phase);
    logic short_hi;
    logic long_hi;
    short_hi = (phase[3:0] < 4'd4);
    long_hi  = (phase[3:0] < 4'd12);
    unique case (trit)
      2'b00:   trit_level = short_hi;
      2'b11:   trit_level = long_hi;
      default: trit_level = phase[4] ? long_hi : short_hi;  // 'F' and reserved 10
    endcase
  endfunction

  logic               osc_s1_q, osc_s2_q, osc_edge_q;
  logic               tick;
  state_e             state_q, state_d;
  logic [PhaseW-1:0]  phase_q, phase_d;
  logic [IdxW-1:0]    trit_idx_q, trit_idx_d;
  logic [CntW-1:0]    word_cnt_q, word_cnt_d;
  logic [2*TRITS-1:0] code_q, code_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               word_done_q, word_done_d;
  logic               start_word;
  logic [CntW-1:0]    cnt_inc;

  // One tick per OSC_CLK rising edge, seen after the two-flop synchroniser.
  assign tick = osc_s2_q & ~osc_edge_q;

  // Next-state: everything advances only on tick cycles.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    trit_idx_d  = trit_idx_q;
    word_cnt_d  = word_cnt_q;
    code_d      = code_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    word_done_d = 1'b0;
    start_word  = 1'b0;
    cnt_inc     = word_cnt_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (TE) begin
            start_word = 1'b1;
            word_cnt_d = '0;
          end
        end
        StTrit: begin
          if (phase_q == TritLast) begin
            phase_d = '0;
            if (trit_idx_q == IdxLast) begin
              state_d = StSync;
            end else begin
              trit_idx_d = trit_idx_q + IdxW'(1);
            end
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        StSync: begin
          if (phase_q == SyncLast) begin
            word_done_d = 1'b1;
            cnt_inc     = (word_cnt_q < CntMax) ? word_cnt_q + CntW'(1) : word_cnt_q;
            word_cnt_d  = cnt_inc;
            if (TE || (cnt_inc < CntMax)) begin
              start_word = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      // Back-to-back words relatch CODE with no idle gap.
      if (start_word) begin
        state_d    = StTrit;
        code_d     = CODE;
        trit_idx_d = '0;
        phase_d    = '0;
      end
      // DOUT shows the level of the phase being entered.
      unique case (state_d)
        StTrit:  dout_d = trit_level(code_d[{trit_idx_d, 1'b0} +: 2], phase_d[4:0]);
        StSync:  dout_d = (phase_d < SyncHigh);
        default: dout_d = 1'b0;
      endcase
      busy_d = (state_d != StIdle);
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge INPUT_CLK or posedge RST) begin
    if (RST) begin
      osc_s1_q    <= 1'b0;
      osc_s2_q    <= 1'b0;
      osc_edge_q  <= 1'b0;
      state_q     <= StIdle;
      phase_q     <= '0;
      trit_idx_q  <= '0;
      word_cnt_q  <= '0;
      code_q      <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      osc_s1_q    <= OSC_CLK;
      osc_s2_q    <= osc_s1_q;
      osc_edge_q  <= osc_s2_q;
      state_q     <= state_d;
      phase_q     <= phase_d;
      trit_idx_q  <= trit_idx_d;
      word_cnt_q  <= word_cnt_d;
      code_q      <= code_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign DOUT      = dout_q;
  assign BUSY      = busy_q;
  assign WORD_DONE = word_done_q;

endmodule
